pipelined_carry_skip_adder: RTL

Parametrised, pipelined carry-skip adder with a valid/ready stream interface. It generalises the fixed 16-bit combinational carry-skip adder to any width, any skip-block size and any number of blocks per pipeline stage. It registers the carry between stages so wide adders close timing, and it accepts one operand pair per cycle. It sits in the datapath wherever a wide adder feeds a throttled consumer.

---
 rtl/csa_pkg.sv | 17 +
 rtl/csa_block.sv | 28 ++
 rtl/pipelined_carry_skip_adder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared defaults, stage-count helper and stage control record for the pipelined carry-skip adder.
package csa_pkg;

  localparam int CSA_WIDTH_DEF = 32;
  localparam int CSA_BLK_DEF   = 4;
  localparam int CSA_BPS_DEF   = 2;

  typedef struct packed {
    logic valid;
    logic carry;
  } csa_ctrl_t;

  function automatic int csa_stages(input int width, input int blk, input int bps);
    return width / (blk * bps);
  endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-skip block: BLK-bit ripple section whose carry out is bypassed
// by the block carry in when every bit propagates.
module csa_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK:0]   c;
  logic [BLK-1:0] p;

  always_comb begin
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[BLK-1:0];
  assign cout = (&p) ? cin : c[BLK];

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder with valid/ready stream ports; each stage adds one
// BLK*BPS-bit slice. Define CSA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_carry_skip_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH_DEF,
  parameter int BLK   = CSA_BLK_DEF,
  parameter int BPS   = CSA_BPS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SEG    = BLK * BPS;
  localparam int STAGES = csa_stages(WIDTH, BLK, BPS);

  if ((WIDTH % SEG) != 0 || WIDTH < SEG) begin : g_bad_cfg
    $error("WIDTH must be a non-zero multiple of BLK*BPS");
  end

  // Handshake: a stage register is free when empty or when its content leaves
  // this cycle; ready_k = !valid_k || ready_{k+1}, ready_STAGES = out_ready.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] cy;
  logic [STAGES:0]   rdy;

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v[k] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int SW = (k + 1) * SEG;
    localparam int RW = WIDTH - SW;

    logic [SEG-1:0] sl_a;
    logic [SEG-1:0] sl_b;
    logic [SEG-1:0] sl_s;
    logic           sl_c;
    logic           up_v;
    logic [BPS:0]   bc;
    logic [SW-1:0]  sum_d;
    logic [SW-1:0]  sum_q;
    csa_ctrl_t      ctrl_q;

    if (k == 0) begin : g_src
      assign sl_a  = a[SEG-1:0];
      assign sl_b  = b[SEG-1:0];
      assign sl_c  = cin;
      assign up_v  = in_valid;
      assign sum_d = sl_s;
    end else begin : g_src
      assign sl_a  = g_stg[k-1].g_up.a_q[SEG-1:0];
      assign sl_b  = g_stg[k-1].g_up.b_q[SEG-1:0];
      assign sl_c  = cy[k-1];
      assign up_v  = v[k-1];
      assign sum_d = {sl_s, g_stg[k-1].sum_q};
    end

    assign bc[0] = sl_c;
    for (genvar j = 0; j < BPS; j++) begin : g_blk
      csa_block #(.BLK(BLK)) u_blk (
        .a    (sl_a[j*BLK +: BLK]),
        .b    (sl_b[j*BLK +: BLK]),
        .cin  (bc[j]),
        .sum  (sl_s[j*BLK +: BLK]),
        .cout (bc[j+1])
      );
    end

    // valid follows upstream whenever this stage may move; payload only on a real load
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctrl_q <= '0;
        sum_q  <= '0;
      end else begin
        if (rdy[k]) begin
          ctrl_q.valid <= up_v;
        end
        if (up_v && rdy[k]) begin
          ctrl_q.carry <= bc[BPS];
          sum_q        <= sum_d;
        end
      end
    end

    assign v[k]  = ctrl_q.valid;
    assign cy[k] = ctrl_q.carry;

    // Operand bits not yet added travel alongside the partial sum.
    if (k < STAGES - 1) begin : g_up
      logic [RW-1:0] a_d;
      logic [RW-1:0] b_d;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;

      if (k == 0) begin : g_in
        assign a_d = a[WIDTH-1:SEG];
        assign b_d = b[WIDTH-1:SEG];
      end else begin : g_in
        assign a_d = g_stg[k-1].g_up.a_q[RW+SEG-1:SEG];
        assign b_d = g_stg[k-1].g_up.b_q[RW+SEG-1:SEG];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (up_v && rdy[k]) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_out
      assign out_valid = ctrl_q.valid;
      assign sum       = sum_q;
      assign cout      = ctrl_q.carry;
`ifdef CSA_OVF_EN
      // The final slice still sees the operand MSBs, so no extra bits are carried.
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (up_v && rdy[k]) begin
          ovf_q <= (sl_a[SEG-1] == sl_b[SEG-1]) && (sl_s[SEG-1] != sl_a[SEG-1]);
        end
      end
      assign ovf = ovf_q;
`endif
    end
  end

endmodule
